// File: rtl/commit_trace_emitter_pkg.sv
// Shared trace definitions for the WISC commit trace emitter.
// Record kinds, FSM states and fixed record field widths.
package commit_trace_emitter_pkg;

    typedef enum logic [2:0] {
        KIND_ALU   = 3'd0,
        KIND_LOAD  = 3'd1,
        KIND_STORE = 3'd2,
        KIND_OTHER = 3'd3,
        KIND_HALT  = 3'd4
    } kind_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int KIND_W = 3;
    localparam int PC_W   = 16;
    localparam int REG_W  = 4;
    localparam int VAL_W  = 16;
    localparam int ADDR_W = 16;

    // Packed record width for a given instruction-number width.
    function automatic int rec_w(input int inum_w);
        return KIND_W + inum_w + PC_W + REG_W + VAL_W + ADDR_W;
    endfunction

endpackage

// File: rtl/commit_trace_emitter_fifo.sv
// Synchronous FIFO holding packed trace records.
// Head is read combinationally from storage; no write-to-read bypass.
module commit_trace_emitter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    // A pop frees the slot, so a push into a full FIFO is legal when popping.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/commit_trace_emitter.sv
// Commit trace emitter: classifies and numbers retiring instructions
// and queues them as trace records drained over valid/ready.
module commit_trace_emitter
    import commit_trace_emitter_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int INUM_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_valid,
    input  logic [15:0]       commit_pc,
    input  logic [15:0]       commit_inst,
    input  logic              reg_we,
    input  logic [3:0]        reg_dst,
    input  logic [15:0]       reg_data,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_data,
    input  logic              halt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [2:0]        rec_kind,
    output logic [INUM_W-1:0] rec_inum,
    output logic [15:0]       rec_pc,
    output logic [3:0]        rec_reg,
    output logic [15:0]       rec_value,
    output logic [15:0]       rec_addr,
    output logic              stall_req,
    output logic              overflow,
    output logic              done
);

    localparam int REC_W = rec_w(INUM_W);
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        kind_e              kind;
        logic [INUM_W-1:0]  inum;
        logic [PC_W-1:0]    pc;
        logic [REG_W-1:0]   rg;
        logic [VAL_W-1:0]   value;
        logic [ADDR_W-1:0]  addr;
    } rec_t;

    state_e            state_q, state_d;
    logic [INUM_W-1:0] inum_q, inum_d;
    logic              ovf_q, ovf_d;

    rec_t              rec_in;
    rec_t              head;
    logic [REC_W-1:0]  rdata;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              accept;
    logic              pop;
    logic              drop;

    // The instruction word is not part of the record.
    logic unused_inst;
    assign unused_inst = ^commit_inst;

    assign accept = commit_valid & (state_q == ST_RUN);
    assign pop    = rec_ready & ~empty;
    assign drop   = accept & full & ~pop;

    // Classify the retiring instruction; earlier tests take priority.
    always_comb begin
        rec_in      = '0;
        rec_in.inum = inum_q;
        rec_in.pc   = commit_pc;
        if (reg_we && mem_re) begin
            rec_in.kind  = KIND_LOAD;
            rec_in.rg    = reg_dst;
            rec_in.value = reg_data;
            rec_in.addr  = mem_addr;
        end else if (reg_we) begin
            rec_in.kind  = KIND_ALU;
            rec_in.rg    = reg_dst;
            rec_in.value = reg_data;
        end else if (halt) begin
            rec_in.kind  = KIND_HALT;
        end else if (mem_we) begin
            rec_in.kind  = KIND_STORE;
            rec_in.value = mem_data;
            rec_in.addr  = mem_addr;
        end else begin
            rec_in.kind  = KIND_OTHER;
        end
    end

    commit_trace_emitter_fifo #(
        .WIDTH(REC_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (accept),
        .pop_i  (pop),
        .wdata_i(rec_in),
        .rdata_o(rdata),
        .full_o (full),
        .empty_o(empty),
        .count_o(count)
    );

    assign head = rec_t'(rdata);

    // Next state: numbering, sticky drop flag, RUN/DRAIN/DONE sequencing.
    // DRAIN also ends on empty so a dropped HALT still finishes.
    always_comb begin
        state_d = state_q;
        inum_d  = inum_q + INUM_W'(accept);
        ovf_d   = ovf_q | drop;
        case (state_q)
            ST_RUN: begin
                if (accept && rec_in.kind == KIND_HALT) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((pop && head.kind == KIND_HALT) || empty) state_d = ST_DONE;
            end
            default: state_d = ST_DONE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            inum_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inum_q  <= inum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rec_valid = ~empty;
    assign rec_kind  = head.kind;
    assign rec_inum  = head.inum;
    assign rec_pc    = head.pc;
    assign rec_reg   = head.rg;
    assign rec_value = head.value;
    assign rec_addr  = head.addr;
    assign stall_req = (count == CW'(DEPTH));
    assign overflow  = ovf_q;
    assign done      = (state_q == ST_DONE);

endmodule
